maxnet_input_loader: RTL and testbench
======================================

Name: maxnet_input_loader

Overview:
Upstream feeder for the MaxNet iteration controller and datapath. Accepts N signed input values over a valid/ready stream and holds them as a stable parallel bus for the datapath's x registers. Issues a one-cycle start pulse to the controller and waits for its done pulse. Then presents a result-valid flag until the host acknowledges it, after which it accepts the next vector.

Parameters:
N, 4, number of input values per vector (2..16)
DW, 8, width of each value, two's complement

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  host presents in_data
in_ready  output  1  loader accepts in_data this cycle
in_data  input  DW  one input value
in_last  input  1  marks final beat of vector (may arrive early)
start  output  1  one-cycle start pulse to controller
done  input  1  one-cycle completion pulse from controller
x_bus  output  N*DW  loaded vector; element i at bits [i*DW +: DW]
busy  output  1  high from first accepted beat until result_ack
result_valid  output  1  controller run finished, x_bus still held
result_ack  input  1  host consumed result
beat_cnt  output  clog2(N+1)  beats captured in current vector

Behaviour:
- Reset (rst=0, asynchronous): state=LOAD, x_bus=0, beat_cnt=0, start=0, busy=0, result_valid=0. in_ready=1 once rst deasserts.
- States:
  - LOAD: in_ready=1. Handshake = in_valid & in_ready on a rising edge. It writes in_data to element beat_cnt and increments beat_cnt. busy goes high on the first handshake.
    - LOAD -> ARM when the handshake has in_last=1, or when it is beat N (beat_cnt reaches N).
    - Early in_last (beat k<N): elements k..N-1 are forced to 0 in the same edge.
  - ARM: in_ready=0. start=1 for exactly this one cycle. Next state is WAIT unconditionally.
    - start must never be high two consecutive cycles, because the controller holds INIT while start=1.
  - WAIT: in_ready=0, start=0. On done=1 the next state is RESULT.
    - done seen in LOAD or ARM is ignored.
  - RESULT: result_valid=1. On result_ack=1: result_valid=0, beat_cnt=0, busy=0, next state LOAD.
    - x_bus keeps its values until overwritten by new beats.
- x_bus is stable (no writes) from the ARM cycle through the RESULT exit.
- Beats offered outside LOAD are not accepted (in_ready=0); the host must hold them.
- in_last on beat N is equivalent to reaching N; there is no extra effect.
- result_ack outside RESULT is ignored. result_ack and done never coincide meaningfully, because done is only sampled in WAIT.
- Reset mid-operation (any state): immediate return to reset values. A start pulse in progress is cut short.
- Latency:
  - Last handshake edge -> start high on the next cycle.
  - done edge -> result_valid high on the next cycle.
  - ack edge -> in_ready high on the next cycle.

Optional Feature:
Macro CLAMP_NEG_EN.
- Defined: each captured in_data with the MSB set is stored as 0, because MaxNet requires non-negative activations.
- Not defined: values are stored verbatim.
- Zero-fill and all handshake timing are identical in both builds.

Test Plan:
- Full vector: N=4, beats 5, 3, 9, 1 with in_last on beat 4 -> x_bus = {1, 9, 3, 5}. start pulses high exactly 1 cycle on the cycle after beat 4. in_ready=0 from that cycle on.
- Early last: beats 7, 2 with in_last on beat 2 -> x_bus = {0, 0, 2, 7}, beat_cnt=2, start pulse follows.
- Backpressure: in_valid held high with data 4 during WAIT -> no capture, x_bus unchanged. Drive done=1 for 1 cycle -> result_valid=1 next cycle. Assert result_ack -> in_ready=1 next cycle and the held beat 4 is captured as element 0.
- Spurious inputs: done pulsed during LOAD and result_ack pulsed during WAIT -> no state change, start never re-asserted.
- Reset mid-run: drive rst=0 asynchronously in WAIT -> x_bus=0, busy=0, result_valid=0 immediately. After release, in_ready=1.
- CLAMP_NEG_EN: beats 0x85, 0x10, 0xFF, 0x7F -> x_bus = {0x7F, 0, 0x10, 0} when defined. Without the macro -> x_bus = {0x7F, 0xFF, 0x10, 0x85}.

Source files
------------

// File: rtl/maxnet_input_loader.sv
// Input loader for MaxNet: collects N signed values from a valid/ready stream,
// pulses start to the controller, waits for done and holds the result for the host.
// Optional build macro CLAMP_NEG_EN stores negative input values as zero.
module maxnet_input_loader #(
  parameter int N  = 4,
  parameter int DW = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_last,
  output logic            start,
  input  logic            done,
  output logic [N*DW-1:0] x_bus,
  output logic            busy,
  output logic            result_valid,
  input  logic            result_ack,
  output logic [CW-1:0]   beat_cnt
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_ARM,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t            r_state;
  logic [N*DW-1:0]   r_x_bus;
  logic [CW-1:0]     r_beat_cnt;
  logic              r_start;
  logic              r_busy;
  logic              r_result_valid;
  logic              w_last;

  // MaxNet activations must be non-negative, so the clamp build zeroes negatives.
  function automatic logic [DW-1:0] clamp_val(input logic signed [DW-1:0] v);
`ifdef CLAMP_NEG_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign w_last = in_last || (r_beat_cnt == CW'(N - 1));

  // Held low while reset is asserted even though the state already reads LOAD.
  assign in_ready     = rst && (r_state == S_LOAD);
  assign start        = r_start;
  assign x_bus        = r_x_bus;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign beat_cnt     = r_beat_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_LOAD;
      r_x_bus        <= '0;
      r_beat_cnt     <= '0;
      r_start        <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            // Early last zero-fills the remaining elements on the same edge.
            for (int i = 0; i < N; i++) begin
              if (i == int'(r_beat_cnt))
                r_x_bus[i*DW +: DW] <= clamp_val(in_data);
              else if (in_last && (i > int'(r_beat_cnt)))
                r_x_bus[i*DW +: DW] <= '0;
            end
            r_beat_cnt <= r_beat_cnt + CW'(1);
            r_busy     <= 1'b1;
            if (w_last) begin
              r_state <= S_ARM;
              r_start <= 1'b1;
            end
          end
        end
        S_ARM: begin
          r_start <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            r_result_valid <= 1'b1;
            r_state        <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (result_ack) begin
            r_result_valid <= 1'b0;
            r_beat_cnt     <= '0;
            r_busy         <= 1'b0;
            r_state        <= S_LOAD;
          end
        end
        default: begin
          r_start <= 1'b0;
          r_state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_input_loader.sv
// Scoreboard bench for maxnet_input_loader: directed cases plus randomized vectors
// checked against a vector-level reference model.
module tb_maxnet_input_loader;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = $clog2(N + 1);

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic            start;
  logic            done;
  logic [N*DW-1:0] x_bus;
  logic            busy;
  logic            result_valid;
  logic            result_ack;
  logic [CW-1:0]   beat_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N*DW-1:0] x;
    logic [CW-1:0]   cnt;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_start;
  logic prev_rv;

  maxnet_input_loader #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .start(start), .done(done),
    .x_bus(x_bus), .busy(busy), .result_valid(result_valid),
    .result_ack(result_ack), .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: value stored for one captured beat.
  function automatic logic [DW-1:0] model_store(input int v);
    logic [DW-1:0] b;
    b = v[DW-1:0];
`ifdef CLAMP_NEG_EN
    if (b[DW-1]) b = '0;
`endif
    return b;
  endfunction

  // Reference model: whole vector after a load of len beats (rest are zero).
  function automatic logic [N*DW-1:0] model_vec(input int vals[N], input int len);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r[i*DW +: DW] = model_store(vals[i]);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int data, input bit last);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = data[DW-1:0];
    in_last  = last;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL beat_timeout: in_ready never rose, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vector_from(input int vals[N], input int len, input int k0);
    exp_t e;
    for (int k = k0; k < len; k++) begin
      idle($urandom_range(0, 1));
      send_beat(vals[k], (k == len - 1) && (len < N || $urandom_range(0, 1) == 1));
    end
    e.x   = model_vec(vals, len);
    e.cnt = CW'(len);
    exp_q.push_back(e);
    chk("start_latency", start, 1);
    chk("in_ready_arm", in_ready, 0);
    @(posedge clk);
    #1;
    chk("start_width", start, 0);
  endtask

  task automatic send_vector(input int vals[N], input int len);
    send_vector_from(vals, len, 0);
  endtask

  task automatic finish_run(input int done_dly, input int ack_dly);
    idle(done_dly);
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    chk("done_to_rv", result_valid, 1);
    idle(ack_dly);
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    chk("ack_in_ready", in_ready, 1);
    chk("ack_rv_clr", result_valid, 0);
    chk("ack_busy_clr", busy, 0);
    chk("ack_cnt_clr", beat_cnt, 0);
  endtask

  // Monitor: start must never be high two cycles running; each new result is
  // compared against the oldest expected vector.
  always @(negedge clk) begin
    if (!rst) begin
      prev_start = 1'b0;
      prev_rv    = 1'b0;
    end else begin
      if (start) chk("start_single", prev_start, 0);
      if (result_valid && !prev_rv) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: result_valid with no expected vector, x_bus %0h", x_bus);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_x_bus", x_bus, mon_e.x);
          chk("sb_beat_cnt", beat_cnt, mon_e.cnt);
          chk("sb_busy", busy, 1);
        end
      end
      prev_start = start;
      prev_rv    = result_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[N];
    int len;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    done = 1'b0;
    result_ack = 1'b0;
    idle(3);
    chk("rst_x_bus", x_bus, 0);
    chk("rst_cnt", beat_cnt, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    rst = 1'b1;
    idle(1);
    chk("rst_in_ready", in_ready, 1);

    // Full vector
    v = '{5, 3, 9, 1};
    send_vector(v, 4);
    chk("full_x_bus", x_bus, 32'h01090305);
    chk("full_cnt", beat_cnt, 4);
    finish_run(2, 1);

    // Early last zero-fills the tail
    v = '{7, 2, 0, 0};
    send_vector(v, 2);
    chk("early_x_bus", x_bus, 32'h00000207);
    chk("early_cnt", beat_cnt, 2);
    finish_run(0, 0);

    // Spurious done in LOAD, spurious ack in WAIT
    done = 1'b1;
    idle(1);
    done = 1'b0;
    chk("spur_done_rv", result_valid, 0);
    chk("spur_done_busy", busy, 0);
    v = '{11, 22, 33, 44};
    send_beat(v[0], 1'b0);
    send_beat(v[1], 1'b0);
    done = 1'b1;
    idle(1);
    done = 1'b0;
    chk("spur_done_cnt", beat_cnt, 2);
    chk("spur_done_ready", in_ready, 1);
    chk("spur_done_start", start, 0);
    send_vector_from(v, 4, 2);
    result_ack = 1'b1;
    idle(1);
    result_ack = 1'b0;
    chk("spur_ack_ready", in_ready, 0);
    chk("spur_ack_rv", result_valid, 0);
    chk("spur_ack_start", start, 0);
    finish_run(1, 2);

    // Backpressure: beat held during WAIT/RESULT
    v = '{6, 8, 0, 0};
    send_vector(v, 2);
    in_valid = 1'b1;
    in_data  = 8'd4;
    in_last  = 1'b0;
    idle(3);
    chk("bp_x_hold", x_bus, 32'h00000806);
    chk("bp_cnt_hold", beat_cnt, 2);
    chk("bp_ready", in_ready, 0);
    finish_run(0, 1);
    chk("bp_valid_held", in_valid, 1);
    send_beat(4, 1'b0);
    chk("bp_elem0", x_bus[7:0], 4);
    chk("bp_elem1_kept", x_bus[15:8], 8);
    chk("bp_cnt", beat_cnt, 1);
    v = '{4, 17, 29, 100};
    send_vector_from(v, 4, 1);
    finish_run(0, 0);

    // Negative values (clamped only in the CLAMP_NEG_EN build)
    v = '{8'h85, 8'h10, 8'hFF, 8'h7F};
    send_vector(v, 4);
`ifdef CLAMP_NEG_EN
    chk("clamp_x_bus", x_bus, 32'h7F001000);
`else
    chk("clamp_x_bus", x_bus, 32'h7FFF1085);
`endif
    finish_run(1, 0);

    // Randomized vectors
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(1, N);
      for (int i = 0; i < N; i++) v[i] = $urandom_range(0, 255);
      send_vector(v, len);
      finish_run($urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset in the middle of a run
    v = '{1, 2, 3, 4};
    send_vector(v, 4);
    idle(1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_x_bus", x_bus, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rv", result_valid, 0);
    chk("mid_rst_cnt", beat_cnt, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    v = '{9, 0, 0, 0};
    send_vector(v, 1);
    finish_run(0, 0);

    idle(2);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
